param_stack: RTL and testbench
==============================

PARAM_STACK -- requirements
Module: param_stack

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter WIDTH, default 8, SHALL set the data width in bits (>=1).
REQ-003 Parameter DEPTH, default 16, SHALL set the entry count (>=2, any integer, not only powers of two).
REQ-004 Parameter CW = $clog2(DEPTH+1) SHALL be derived locally and never overridden.
REQ-005 Ports SHALL be:
  clk  in  1  rising-edge clock
  reset_n  in  1  async active-low reset
  clear  in  1  sync flush, empties stack
  push  in  1  write data_in onto top
  pop  in  1  remove top entry
  data_in  in  WIDTH  push data
  data_out  out  WIDTH  registered value of last popped entry
  top  out  WIDTH  current top entry (combinational peek)
  count  out  CW  entries held
  empty  out  1  count==0
  full  out  1  count==DEPTH
  overflow  out  1  sticky: push rejected while full
  underflow  out  1  sticky: pop rejected while empty

Function
REQ-006 All state SHALL update only on rising clk; all outputs except top SHALL be registered or decoded from registered count.
REQ-007 Push only, not full: the block SHALL write data_in at index count and set count+1; the pushed value SHALL appear on top in the next cycle.
REQ-008 Pop only, not empty: data_out SHALL take the top entry on the same edge, giving 1-cycle latency, and count SHALL become count-1.
REQ-009 Push and pop together, not empty: data_out SHALL take the old top, the top slot SHALL be overwritten with data_in, and count SHALL stay unchanged.
REQ-010 Push and pop together while empty: the pop SHALL be rejected (underflow set), the push SHALL proceed, and count SHALL become 1.
REQ-011 Push while full without pop: the push SHALL be ignored, memory and count SHALL be unchanged, and overflow SHALL be set.
REQ-012 Push and pop together while full: the replace of REQ-009 SHALL apply, and overflow SHALL NOT be set.
REQ-013 Pop while empty without push: data_out SHALL hold, count SHALL stay 0, and underflow SHALL be set.
REQ-014 overflow and underflow SHALL stay set until reset_n or clear.
REQ-015 clear SHALL override push and pop: count, overflow and underflow SHALL go to 0, and data_out SHALL hold; memory contents need not be erased.
REQ-016 top SHALL equal the entry at index count-1 when not empty, and 0 when empty.
REQ-017 count SHALL never exceed DEPTH and SHALL never wrap below 0.

Reset
REQ-018 reset_n low SHALL immediately force count=0, data_out=0, overflow=0 and underflow=0, giving empty=1 and full=0.
REQ-019 Memory contents SHALL NOT be reset.
REQ-020 Reset asserted mid-operation SHALL discard all entries, and push or pop in the first cycle after deassertion SHALL behave normally.

Structure
REQ-021 Package stack_pkg SHALL hold default WIDTH/DEPTH constants and a typedef for the op encoding {NOP, PUSH, POP, REPLACE}.
REQ-022 Storage SHALL be a sub-module stack_mem: a DEPTH x WIDTH register array with one write port and one async read port.
REQ-023 param_stack SHALL hold the pointer, flags and op decode.

Verification
REQ-024 Reset, then push 0xA4 -> next cycle top=0xA4, count=1; pop -> data_out=0xA4 one cycle later, empty=1.
REQ-025 Push 0x01..0x10 with DEPTH=16 -> full=1, count=16; push 0xFF -> overflow=1, top=0x10; pop 16 times -> data_out sequence 0x10..0x01.
REQ-026 With count=3 and top=0x33, push+pop with data_in=0xC2 -> data_out=0x33, top=0xC2, count=3.
REQ-027 Pop on empty -> underflow=1, data_out unchanged; push+pop on empty with 0x5A -> count=1, top=0x5A.
REQ-028 Push 5 entries with overflow set, then clear -> count=0, overflow=0, empty=1; push 0x77 -> top=0x77.
REQ-029 Assert reset_n low mid-clock with count=7 -> count=0 and data_out=0 before the next edge; rerun REQ-024 with WIDTH=12, DEPTH=5.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared constants and operation encoding for the parameterised LIFO stack.
package stack_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 16;

    // Operation actually performed on a clock edge, after rejection rules apply.
    typedef enum logic [1:0] {
        NOP     = 2'd0,
        PUSH    = 2'd1,
        POP     = 2'd2,
        REPLACE = 2'd3
    } stack_op_e;

    // Resolve the raw push/pop requests against the current fill state.
    // Push+pop on an empty stack degrades to a plain push (the pop is the
    // rejected half). Push+pop on a full stack is a replace, not an overflow.
    function automatic stack_op_e decode_op(
        input logic push_s,
        input logic pop_s,
        input logic empty_s,
        input logic full_s
    );
        stack_op_e op_v;
        if (push_s && pop_s && !empty_s) begin
            op_v = REPLACE;
        end else if (push_s && !full_s) begin
            op_v = PUSH;
        end else if (pop_s && !push_s && !empty_s) begin
            op_v = POP;
        end else begin
            op_v = NOP;
        end
        return op_v;
    endfunction

endpackage

// File: rtl/stack_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one async read port.
// Contents are intentionally not reset.
module stack_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [WIDTH-1:0]           rd_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write the addressed entry when enabled.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/param_stack.sv
// Parameterised LIFO stack: stack pointer, sticky error flags and op decode.
// Storage lives in stack_mem; top is a combinational peek of the newest entry.
module param_stack
    import stack_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          clear,
    input  logic                          push,
    input  logic                          pop,
    input  logic [WIDTH-1:0]              data_in,
    output logic [WIDTH-1:0]              data_out,
    output logic [WIDTH-1:0]              top,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic                          empty,
    output logic                          full,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_nxt_s;
    logic [WIDTH-1:0] data_out_r;
    logic [WIDTH-1:0] data_out_nxt_s;
    logic             overflow_r;
    logic             overflow_nxt_s;
    logic             underflow_r;
    logic             underflow_nxt_s;

    logic             empty_s;
    logic             full_s;
    stack_op_e        op_s;
    logic [CW-1:0]    top_idx_s;
    logic [AW-1:0]    rd_addr_s;
    logic [AW-1:0]    wr_addr_s;
    logic             wr_en_s;
    logic [WIDTH-1:0] rd_data_s;

    assign empty_s   = (count_r == {CW{1'b0}});
    assign full_s    = (count_r == DEPTH_C);
    assign op_s      = decode_op(push, pop, empty_s, full_s);
    assign top_idx_s = count_r - ONE_C;

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en_s),
        .wr_addr (wr_addr_s),
        .wr_data (data_in),
        .rd_addr (rd_addr_s),
        .rd_data (rd_data_s)
    );

    // Memory port addressing: read the newest entry, write at count or replace the top.
    always_comb begin
        rd_addr_s = {AW{1'b0}};
        wr_addr_s = {AW{1'b0}};
        wr_en_s   = 1'b0;
        if (empty_s) begin
            rd_addr_s = {AW{1'b0}};
        end else begin
            rd_addr_s = top_idx_s[AW-1:0];
        end
        case (op_s)
            PUSH: begin
                wr_en_s   = !clear;
                wr_addr_s = count_r[AW-1:0];
            end
            REPLACE: begin
                wr_en_s   = !clear;
                wr_addr_s = top_idx_s[AW-1:0];
            end
            default: begin
                wr_en_s   = 1'b0;
                wr_addr_s = {AW{1'b0}};
            end
        endcase
    end

    // Next pointer, popped data and sticky flags; clear overrides every request.
    always_comb begin
        count_nxt_s     = count_r;
        data_out_nxt_s  = data_out_r;
        overflow_nxt_s  = overflow_r;
        underflow_nxt_s = underflow_r;
        if (clear) begin
            count_nxt_s     = {CW{1'b0}};
            overflow_nxt_s  = 1'b0;
            underflow_nxt_s = 1'b0;
        end else begin
            case (op_s)
                PUSH:    count_nxt_s = count_r + ONE_C;
                POP: begin
                    count_nxt_s    = count_r - ONE_C;
                    data_out_nxt_s = rd_data_s;
                end
                REPLACE: data_out_nxt_s = rd_data_s;
                default: count_nxt_s = count_r;
            endcase
            if (push && !pop && full_s) begin
                overflow_nxt_s = 1'b1;
            end else begin
                overflow_nxt_s = overflow_r;
            end
            if (pop && empty_s) begin
                underflow_nxt_s = 1'b1;
            end else begin
                underflow_nxt_s = underflow_r;
            end
        end
    end

    // State registers; reset empties the stack but leaves memory contents alone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r     <= {CW{1'b0}};
            data_out_r  <= {WIDTH{1'b0}};
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            count_r     <= count_nxt_s;
            data_out_r  <= data_out_nxt_s;
            overflow_r  <= overflow_nxt_s;
            underflow_r <= underflow_nxt_s;
        end
    end

    assign data_out  = data_out_r;
    assign count     = count_r;
    assign empty     = empty_s;
    assign full      = full_s;
    assign overflow  = overflow_r;
    assign underflow = underflow_r;
    assign top       = empty_s ? {WIDTH{1'b0}} : rd_data_s;

endmodule

// File: tb/tb_param_stack.sv
// Directed self-checking bench for param_stack: default 8x16 instance plus a 12x5 instance.
module tb_param_stack;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    logic       d_clear, d_push, d_pop;
    logic [7:0] d_data_in, d_data_out, d_top;
    logic [4:0] d_count;
    logic       d_empty, d_full, d_overflow, d_underflow;

    logic        e_clear, e_push, e_pop;
    logic [11:0] e_data_in, e_data_out, e_top;
    logic [2:0]  e_count;
    logic        e_empty, e_full, e_overflow, e_underflow;

    int compared   = 0;
    int mismatched = 0;

    param_stack d_dut (
        .clk(clk), .reset_n(reset_n), .clear(d_clear), .push(d_push), .pop(d_pop),
        .data_in(d_data_in), .data_out(d_data_out), .top(d_top), .count(d_count),
        .empty(d_empty), .full(d_full), .overflow(d_overflow), .underflow(d_underflow)
    );

    param_stack #(.WIDTH(12), .DEPTH(5)) e_dut (
        .clk(clk), .reset_n(reset_n), .clear(e_clear), .push(e_push), .pop(e_pop),
        .data_in(e_data_in), .data_out(e_data_out), .top(e_top), .count(e_count),
        .empty(e_empty), .full(e_full), .overflow(e_overflow), .underflow(e_underflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        d_clear = 1'b0; d_push = 1'b0; d_pop = 1'b0; d_data_in = 8'h00;
        e_clear = 1'b0; e_push = 1'b0; e_pop = 1'b0; e_data_in = 12'h000;
        #1;
        check("rst_count", 32'(d_count), 32'd0);
        check("rst_empty", 32'(d_empty), 32'd1);
        check("rst_full", 32'(d_full), 32'd0);
        check("rst_dout", 32'(d_data_out), 32'd0);
        check("rst_ovf", 32'(d_overflow), 32'd0);
        check("rst_udf", 32'(d_underflow), 32'd0);
        check("rst_top", 32'(d_top), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // single push then pop
        d_push = 1'b1; d_data_in = 8'hA4;
        tick();
        d_push = 1'b0;
        check("push_top", 32'(d_top), 32'hA4);
        check("push_count", 32'(d_count), 32'd1);
        check("push_empty", 32'(d_empty), 32'd0);
        d_pop = 1'b1;
        tick();
        d_pop = 1'b0;
        check("pop_dout", 32'(d_data_out), 32'hA4);
        check("pop_empty", 32'(d_empty), 32'd1);
        check("pop_count", 32'(d_count), 32'd0);
        check("pop_top", 32'(d_top), 32'd0);

        // 12x5 instance: push/pop, then fill and overflow
        e_push = 1'b1; e_data_in = 12'hABC;
        tick();
        e_push = 1'b0;
        check("e_push_top", 32'(e_top), 32'hABC);
        check("e_push_count", 32'(e_count), 32'd1);
        e_pop = 1'b1;
        tick();
        e_pop = 1'b0;
        check("e_pop_dout", 32'(e_data_out), 32'hABC);
        check("e_pop_empty", 32'(e_empty), 32'd1);
        for (int i = 1; i <= 5; i++) begin
            e_push = 1'b1; e_data_in = 12'(i * 256 + i);
            tick();
        end
        check("e_full", 32'(e_full), 32'd1);
        check("e_count5", 32'(e_count), 32'd5);
        e_data_in = 12'hFFF;
        tick();
        e_push = 1'b0;
        check("e_ovf", 32'(e_overflow), 32'd1);
        check("e_ovf_top", 32'(e_top), 32'h505);
        check("e_ovf_count", 32'(e_count), 32'd5);

        // pop on empty, then push+pop on empty
        d_pop = 1'b1;
        tick();
        check("udf_flag", 32'(d_underflow), 32'd1);
        check("udf_dout_hold", 32'(d_data_out), 32'hA4);
        check("udf_count", 32'(d_count), 32'd0);
        d_push = 1'b1; d_data_in = 8'h5A;
        tick();
        d_push = 1'b0; d_pop = 1'b0;
        check("pp_empty_count", 32'(d_count), 32'd1);
        check("pp_empty_top", 32'(d_top), 32'h5A);
        check("pp_empty_dout", 32'(d_data_out), 32'hA4);
        d_clear = 1'b1;
        tick();
        d_clear = 1'b0;
        check("clr_count", 32'(d_count), 32'd0);
        check("clr_udf", 32'(d_underflow), 32'd0);
        check("clr_dout_hold", 32'(d_data_out), 32'hA4);

        // fill, overflow, drain
        for (int i = 1; i <= 16; i++) begin
            d_push = 1'b1; d_data_in = 8'(i);
            tick();
        end
        check("fill_full", 32'(d_full), 32'd1);
        check("fill_count", 32'(d_count), 32'd16);
        d_data_in = 8'hFF;
        tick();
        d_push = 1'b0;
        check("ovf_flag", 32'(d_overflow), 32'd1);
        check("ovf_top", 32'(d_top), 32'h10);
        check("ovf_count", 32'(d_count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            d_pop = 1'b1;
            tick();
            check("drain_dout", 32'(d_data_out), 32'(16 - i));
        end
        d_pop = 1'b0;
        check("drain_empty", 32'(d_empty), 32'd1);
        check("ovf_sticky", 32'(d_overflow), 32'd1);

        // replace with count=3
        for (int i = 1; i <= 3; i++) begin
            d_push = 1'b1; d_data_in = 8'(i * 17);
            tick();
        end
        check("r3_count", 32'(d_count), 32'd3);
        check("r3_top", 32'(d_top), 32'h33);
        d_pop = 1'b1; d_data_in = 8'hC2;
        tick();
        d_pop = 1'b0;
        check("rep_dout", 32'(d_data_out), 32'h33);
        check("rep_top", 32'(d_top), 32'hC2);
        check("rep_count", 32'(d_count), 32'd3);
        d_data_in = 8'h44;
        tick();
        d_data_in = 8'h55;
        tick();
        d_push = 1'b0;
        check("c5_count", 32'(d_count), 32'd5);
        check("c5_ovf", 32'(d_overflow), 32'd1);
        d_clear = 1'b1; d_push = 1'b1; d_data_in = 8'hEE;
        tick();
        d_clear = 1'b0;
        check("clr2_count", 32'(d_count), 32'd0);
        check("clr2_ovf", 32'(d_overflow), 32'd0);
        check("clr2_empty", 32'(d_empty), 32'd1);
        d_data_in = 8'h77;
        tick();
        check("after_clr_top", 32'(d_top), 32'h77);

        // replace while full must not raise overflow
        for (int i = 1; i <= 15; i++) begin
            d_data_in = 8'(8'h80 + i);
            tick();
        end
        check("full2", 32'(d_full), 32'd1);
        d_pop = 1'b1; d_data_in = 8'hEE;
        tick();
        d_push = 1'b0; d_pop = 1'b0;
        check("frep_dout", 32'(d_data_out), 32'h8F);
        check("frep_top", 32'(d_top), 32'hEE);
        check("frep_count", 32'(d_count), 32'd16);
        check("frep_no_ovf", 32'(d_overflow), 32'd0);

        // asynchronous reset mid-cycle with count=7
        d_clear = 1'b1;
        tick();
        d_clear = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            d_push = 1'b1; d_data_in = 8'(i);
            tick();
        end
        d_push = 1'b0;
        check("c7_count", 32'(d_count), 32'd7);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_count", 32'(d_count), 32'd0);
        check("arst_dout", 32'(d_data_out), 32'd0);
        check("arst_empty", 32'(d_empty), 32'd1);
        check("arst_top", 32'(d_top), 32'd0);
        check("arst_e_dout", 32'(e_data_out), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        d_push = 1'b1; d_data_in = 8'h42;
        tick();
        d_push = 1'b0;
        check("post_rst_top", 32'(d_top), 32'h42);
        check("post_rst_count", 32'(d_count), 32'd1);
        d_pop = 1'b1;
        tick();
        d_pop = 1'b0;
        check("post_rst_dout", 32'(d_data_out), 32'h42);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
